// File: rtl/ibex_cheri_exc_reporter.sv
// CHERI capability-violation reporter: priority-encodes the violation vector into a
// cause/index pair, holds the trap request, and commits accepted traps into MCCSR.
module ibex_cheri_exc_reporter #(
  parameter int unsigned NumViolations = 22
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     violation_valid_i,
  input  logic [NumViolations-1:0] violation_i,
  input  logic [2:0]               exc_reg_sel_i,
  input  logic [4:0]               reg_a_addr_i,
  input  logic [4:0]               reg_b_addr_i,
  input  logic [4:0]               scr_addr_i,
  output logic                     exc_req_o,
  input  logic                     exc_ack_i,
  input  logic                     flush_i,
  output logic [4:0]               c_cause_o,
  output logic [5:0]               cap_idx_o,
  input  logic                     csr_access_i,
  input  logic [11:0]              csr_addr_i,
  input  logic [1:0]               csr_op_i,
  input  logic [31:0]              csr_wdata_i,
  output logic                     csr_hit_o,
  output logic [31:0]              csr_rdata_o
);

  localparam logic [11:0] CSR_MCCSR = 12'hBC0;

  typedef enum logic [2:0] {
    REG_A   = 3'd0,
    REG_B   = 3'd1,
    REG_SCR = 3'd2,
    REG_PCC = 3'd3
  } c_exc_reg_mux_sel_e;

  typedef enum logic [1:0] {
    CSR_OP_READ  = 2'd0,
    CSR_OP_WRITE = 2'd1,
    CSR_OP_SET   = 2'd2,
    CSR_OP_CLEAR = 2'd3
  } csr_op_e;

  typedef enum logic {
    IDLE,
    PENDING
  } state_e;

  state_e      state_q, state_d;
  logic        latch_en, commit_en;
  logic [4:0]  win_idx;
  logic [4:0]  new_cause;
  logic [5:0]  new_cap_idx;
  logic [4:0]  pend_cause_q;
  logic [5:0]  pend_idx_q;
  logic [4:0]  mccsr_cause_q;
  logic [5:0]  mccsr_idx_q;
  logic [31:0] mccsr_value;
  logic [31:0] csr_wr_value;
  logic        csr_wr_en;
  logic        unused_wdata;

  // Lowest set index wins, so scan downwards and let the last hit stick.
  always_comb begin
    win_idx = '0;
    for (int i = NumViolations - 1; i >= 0; i--) begin
      if (violation_i[i]) begin
        win_idx = 5'(i);
      end
    end
  end

  always_comb begin
    case (win_idx)
      5'd0:    new_cause = 5'h18;
      5'd1:    new_cause = 5'h02;
      5'd2:    new_cause = 5'h03;
      5'd3:    new_cause = 5'h04;
      5'd4:    new_cause = 5'h17;
      5'd5:    new_cause = 5'h19;
      5'd6:    new_cause = 5'h1A;
      5'd7:    new_cause = 5'h1B;
      5'd8:    new_cause = 5'h1C;
      5'd9:    new_cause = 5'h11;
      5'd10:   new_cause = 5'h12;
      5'd11:   new_cause = 5'h13;
      5'd12:   new_cause = 5'h14;
      5'd13:   new_cause = 5'h15;
      5'd14:   new_cause = 5'h16;
      5'd15:   new_cause = 5'h10;
      5'd16:   new_cause = 5'h01;
      5'd17:   new_cause = 5'h0A;
      5'd18:   new_cause = 5'h08;
      5'd19:   new_cause = 5'h09;
      5'd20:   new_cause = 5'h05;
      5'd21:   new_cause = 5'h06;
      default: new_cause = 5'h00;
    endcase
  end

  always_comb begin
    case (exc_reg_sel_i)
      REG_A:   new_cap_idx = {1'b0, reg_a_addr_i};
      REG_B:   new_cap_idx = {1'b0, reg_b_addr_i};
      REG_SCR: new_cap_idx = {1'b1, scr_addr_i};
      REG_PCC: new_cap_idx = 6'h20;
      default: new_cap_idx = 6'h00;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    latch_en  = 1'b0;
    commit_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (violation_valid_i && |violation_i) begin
          state_d  = PENDING;
          latch_en = 1'b1;
        end
      end
      PENDING: begin
        // A flush kills the trap even if the controller acks it in the same cycle.
        if (flush_i) begin
          state_d = IDLE;
        end else if (exc_ack_i) begin
          state_d   = IDLE;
          commit_en = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      pend_cause_q <= '0;
      pend_idx_q   <= '0;
    end else begin
      state_q <= state_d;
      if (latch_en) begin
        pend_cause_q <= new_cause;
        pend_idx_q   <= new_cap_idx;
      end
    end
  end

  assign exc_req_o = (state_q == PENDING);
  assign c_cause_o = pend_cause_q;
  assign cap_idx_o = pend_idx_q;

  assign mccsr_value = {16'h0000, mccsr_idx_q, mccsr_cause_q, 4'h0, 1'b1};
  assign csr_hit_o   = (csr_addr_i == CSR_MCCSR);
  assign csr_rdata_o = csr_hit_o ? mccsr_value : 32'h0;
  assign csr_wr_en   = csr_access_i && csr_hit_o && (csr_op_i != CSR_OP_READ);

  always_comb begin
    case (csr_op_i)
      CSR_OP_WRITE: csr_wr_value = csr_wdata_i;
      CSR_OP_SET:   csr_wr_value = mccsr_value | csr_wdata_i;
      CSR_OP_CLEAR: csr_wr_value = mccsr_value & ~csr_wdata_i;
      default:      csr_wr_value = mccsr_value;
    endcase
  end

  // Only the cause/index field is writable; E and the zero fields are fixed.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mccsr_cause_q <= '0;
      mccsr_idx_q   <= '0;
    end else if (commit_en) begin
      mccsr_cause_q <= pend_cause_q;
      mccsr_idx_q   <= pend_idx_q;
    end else if (csr_wr_en) begin
      mccsr_cause_q <= csr_wr_value[9:5];
      mccsr_idx_q   <= csr_wr_value[15:10];
    end
  end

  assign unused_wdata = ^{csr_wr_value[31:16], csr_wr_value[4:0]};

endmodule
